// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: builds and selects the immediate, registers
// operands, PC and rd for EX, and counts bubbles (saturating).
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   stall, flush     : hold EX registers / squash incoming instruction
//   id_valid         : decode holds a real instruction
//   id_instr, id_pc  : raw instruction word and its PC
//   id_rd1, id_rd2   : register-file operands
//   id_zext_imm      : zero-extended ALU imm12
//   id_imm_sel       : immediate form select
//   ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rd : registered EX bundle
//   bubble_cnt       : bubbles inserted since reset, saturating
module id_ex_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [63:0]      id_pc,
  input  logic [63:0]      id_rd1,
  input  logic [63:0]      id_rd2,
  input  logic [63:0]      id_zext_imm,
  input  logic [2:0]       id_imm_sel,
  output logic             ex_valid,
  output logic [63:0]      ex_pc,
  output logic [63:0]      ex_a,
  output logic [63:0]      ex_b,
  output logic [63:0]      ex_imm,
  output logic [4:0]       ex_rd,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [4:0]  rd;
  } id_ex_t;

  id_ex_t           q;
  id_ex_t           d;
  logic [63:0]      imm;
  logic [5:0]       mov_sh;
  logic             bubble;
  logic [CNT_W-1:0] cnt;

  assign mov_sh = {id_instr[22:21], 4'b0000};

  always_comb begin
    imm = '0;
    case (id_imm_sel)
      3'd1: imm = id_zext_imm;
      3'd2: imm = {{55{id_instr[20]}}, id_instr[20:12]};
      3'd3: imm = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};
      3'd4: imm = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
      3'd5: imm = {48'd0, id_instr[20:5]} << mov_sh;
      3'd6: imm = {58'd0, id_instr[15:10]};
      default: imm = '0;
    endcase
  end

  always_comb begin
    d       = '0;
    d.valid = 1'b1;
    d.pc    = id_pc;
    d.a     = id_rd1;
    d.b     = id_rd2;
    d.imm   = imm;
    d.rd    = id_instr[4:0];
  end

  // A bubble enters EX on a flush, or on an unstalled load of nothing.
  assign bubble = flush | (~stall & ~id_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      if (flush)
        q <= '0;
      else if (!stall)
        q <= id_valid ? d : '0;
      if (bubble && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end

  assign ex_valid   = q.valid;
  assign ex_pc      = q.pc;
  assign ex_a       = q.a;
  assign ex_b       = q.b;
  assign ex_imm     = q.imm;
  assign ex_rd      = q.rd;
  assign bubble_cnt = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps plus random traffic against a
// behavioural model; a CNT_W=3 copy checks counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc, id_rd1, id_rd2, id_zext_imm;
  logic [2:0]  id_imm_sel;

  logic        ex_valid, s_valid;
  logic [63:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [63:0] s_pc, s_a, s_b, s_imm;
  logic [4:0]  ex_rd, s_rd;
  logic [31:0] bubble_cnt;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_zext_imm(id_zext_imm),
    .id_imm_sel(id_imm_sel), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_zext_imm(id_zext_imm),
    .id_imm_sel(id_imm_sel), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_a(s_a), .ex_b(s_b), .ex_imm(s_imm), .ex_rd(s_rd),
    .bubble_cnt(s_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic        m_valid;
  logic [63:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  int          m_n;

  function automatic logic [63:0] ref_imm(
    input logic [2:0] sel, input logic [31:0] ins,
    input logic [63:0] zx);
    logic signed [8:0]  d9;
    logic signed [18:0] c19;
    logic signed [25:0] b26;
    longint             v;
    case (sel)
      3'd1: return zx;
      3'd2: begin d9 = ins[20:12]; v = d9; return 64'(v); end
      3'd3: begin c19 = ins[23:5]; v = c19; return 64'(v * 4); end
      3'd4: begin b26 = ins[25:0]; v = b26; return 64'(v * 4); end
      3'd5: return 64'(ins[20:5]) << (16 * int'(ins[22:21]));
      3'd6: return 64'(ins[15:10]);
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic v, input logic [2:0] sel,
                      input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] zx);
    reset = r; stall = st; flush = fl; id_valid = v;
    id_imm_sel = sel; id_instr = ins; id_pc = pc;
    id_rd1 = a; id_rd2 = b; id_zext_imm = zx;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0;
      m_n = 0;
    end else if (fl || (!st && !v)) begin
      m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0;
      m_n++;
    end else if (!st) begin
      m_valid = 1; m_pc = pc; m_a = a; m_b = b;
      m_imm = ref_imm(sel, ins, zx); m_rd = ins[4:0];
    end
    check("valid", 64'(ex_valid), 64'(m_valid));
    check("pc", ex_pc, m_pc);
    check("a", ex_a, m_a);
    check("b", ex_b, m_b);
    check("imm", ex_imm, m_imm);
    check("rd", 64'(ex_rd), 64'(m_rd));
    check("cnt", 64'(bubble_cnt), 64'(m_n));
    check("cnt3", 64'(s_cnt), 64'((m_n > 7) ? 7 : m_n));
    check("imm3", s_imm, m_imm);
  endtask

  logic [31:0] ins;
  int          cnt_before;

  initial begin
    m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0;
    m_n = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 1, 2, 3, 4);
    check("rst_valid", 64'(ex_valid), 0);
    check("rst_cnt", 64'(bubble_cnt), 0);

    ins = 32'd3;
    step(0, 0, 0, 1, 1, ins, 64'h40, 5, 7, 64'hC93);
    check("t1_imm", ex_imm, 64'h0C93);
    check("t1_pc", ex_pc, 64'h40);
    check("t1_rd", 64'(ex_rd), 3);
    check("t1_valid", 64'(ex_valid), 1);

    ins = 0; ins[20:12] = 9'h1F8;
    step(0, 0, 0, 1, 2, ins, 64'h44, 1, 2, 0);
    check("daddr", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    ins = 0; ins[23:5] = 19'h7FFFF;
    step(0, 0, 0, 1, 3, ins, 64'h48, 1, 2, 0);
    check("cond", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    ins = 0; ins[25:0] = 26'h10;
    step(0, 0, 0, 1, 4, ins, 64'h4C, 1, 2, 0);
    check("br", ex_imm, 64'h40);
    ins = 0; ins[20:5] = 16'hBEEF; ins[22:21] = 2;
    step(0, 0, 0, 1, 5, ins, 64'h50, 1, 2, 0);
    check("movz2", ex_imm, 64'h0000_BEEF_0000_0000);
    ins[22:21] = 3;
    step(0, 0, 0, 1, 5, ins, 64'h54, 1, 2, 0);
    check("movz3", ex_imm, 64'hBEEF_0000_0000_0000);
    ins = 0; ins[15:10] = 6'h3F;
    step(0, 0, 0, 1, 6, ins, 64'h58, 1, 2, 0);
    check("shamt", ex_imm, 64'h3F);
    step(0, 0, 0, 1, 7, 32'hFFFF_FFFF, 64'h5C, 1, 2, 64'h123);
    check("sel7", ex_imm, 0);

    step(0, 0, 0, 1, 1, 32'h11, 64'hA0, 64'hAA, 64'hBB, 64'h77);
    cnt_before = m_n;
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, i[0], 3'(i + 2), $urandom, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, 64'h5);
    check("stall_pc", ex_pc, 64'hA0);
    check("stall_imm", ex_imm, 64'h77);
    check("stall_cnt", 64'(bubble_cnt), 64'(cnt_before));
    step(0, 1, 1, 1, 1, 32'h1, 64'h1, 1, 1, 1);
    check("sf_valid", 64'(ex_valid), 0);
    check("sf_imm", ex_imm, 0);
    check("sf_cnt", 64'(bubble_cnt), 64'(cnt_before + 1));

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 32'h5, 64'h8, 1, 1, 1);
    check("b4_cnt", 64'(bubble_cnt), 4);
    check("b4_valid", 64'(ex_valid), 0);
    step(0, 0, 0, 1, 1, 32'h9, 64'hC0, 3, 4, 5);
    step(0, 1, 0, 1, 1, 32'h9, 64'hC4, 3, 4, 5);
    step(0, 1, 0, 1, 1, 32'h9, 64'hC8, 3, 4, 5);
    step(1, 1, 0, 1, 1, 32'h9, 64'hCC, 3, 4, 5);
    check("rs_cnt", 64'(bubble_cnt), 0);
    check("rs_pc", ex_pc, 0);
    step(0, 0, 0, 1, 1, 32'h9, 64'hD0, 3, 4, 5);
    check("post_rst_pc", ex_pc, 64'hD0);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, (i % 2) == 0, 0, 0, 0, 0, 0, 0, 0);
      check("sat3", 64'(s_cnt), 64'((i > 7) ? 7 : i));
    end

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           3'($urandom), $urandom, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom},
           64'($urandom_range(0, 4095)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage 64-bit CPU.
- Consumes the zero-extended 12-bit ALU immediate from the decode-stage zero extender.
- Builds every other immediate form from the raw 32-bit instruction and selects one.
- Registers the selected immediate, both register-file operands, PC and destination register for the EX stage, with stall, flush and bubble tracking.

Parameters:
CNT_W, 32, width of the saturating bubble counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold all EX-side registers this cycle
flush  input  1  replace incoming instruction with a bubble
id_valid  input  1  decode stage holds a real instruction
id_instr  input  32  raw instruction word
id_pc  input  64  PC of the instruction
id_rd1  input  64  register-file read data 1
id_rd2  input  64  register-file read data 2
id_zext_imm  input  64  ALU_imm12 already zero-extended to 64 bits
id_imm_sel  input  3  immediate form select (encoding below)
ex_valid  output  1  EX stage holds a real instruction
ex_pc  output  64  registered PC
ex_a  output  64  registered operand A (id_rd1)
ex_b  output  64  registered operand B (id_rd2)
ex_imm  output  64  registered selected immediate
ex_rd  output  5  registered destination register, id_instr[4:0]
bubble_cnt  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Immediate select, combinational, before the register. Unlisted codes give 0.
  - 0: zero (no immediate)
  - 1: id_zext_imm, passed through unchanged
  - 2: DAddr9, sign-extend id_instr[20:12]
  - 3: CondAddr19, sign-extend id_instr[23:5], then shift left 2
  - 4: BrAddr26, sign-extend id_instr[25:0], then shift left 2
  - 5: MOVZ, zero-extend id_instr[20:5], then shift left by 16*id_instr[22:21]; hw=3 gives imm16 at bits 63:48
  - 6: shamt, zero-extend id_instr[15:10]
  - 7: zero
- All arithmetic is 64-bit. Shifts discard bits shifted out above bit 63.
- Latency: exactly 1 cycle from ID inputs to EX outputs.
- Per-edge priority: reset > flush > stall > load.
  - reset: ex_valid=0; ex_pc, ex_a, ex_b, ex_imm = 0; ex_rd=0; bubble_cnt=0.
  - flush (stall value ignored): ex_valid=0; all data outputs cleared to 0 (ex_rd=0); bubble_cnt increments.
  - stall without flush: every output holds its value, including bubble_cnt.
  - load with id_valid=1: all fields captured; ex_valid=1.
  - load with id_valid=0: same as a bubble (ex_valid=0, data fields 0, bubble_cnt increments).
- bubble_cnt saturates at all-ones. It never wraps.
- Reset asserted mid-stall or mid-flush: reset wins on that edge. The first normal load happens on the first edge with reset=0.
- The design has no combinational path from any input to any output. All outputs come straight from flops.

Test Plan:
- Reset, then load id_valid=1, imm_sel=1, id_zext_imm=0xC93, id_pc=0x40, rd1=5, rd2=7, instr[4:0]=3 -> next edge: ex_valid=1, ex_imm=0x0000_0000_0000_0C93, ex_pc=0x40, ex_a=5, ex_b=7, ex_rd=3.
- imm_sel=2, instr[20:12]=0x1F8 -> ex_imm=0xFFFF_FFFF_FFFF_FFF8. Then imm_sel=3, instr[23:5]=0x7FFFF -> ex_imm=0xFFFF_FFFF_FFFF_FFFC. Then imm_sel=4, instr[25:0]=0x0000010 -> ex_imm=0x40.
- imm_sel=5, instr[20:5]=0xBEEF, instr[22:21]=2 -> ex_imm=0x0000_BEEF_0000_0000. Same with hw=3 -> 0xBEEF_0000_0000_0000. imm_sel=6, instr[15:10]=0x3F -> 0x3F. imm_sel=7 -> 0.
- Load valid instr A, then stall=1 for 3 cycles while inputs change -> ex_* still equal A and bubble_cnt unchanged. Then stall=1 and flush=1 together -> ex_valid=0, ex_imm=0, bubble_cnt=+1.
- id_valid=0 for 4 consecutive loads -> ex_valid=0 and bubble_cnt=4. Assert reset during the third stall cycle -> next edge all outputs 0, bubble_cnt=0.
- CNT_W=3: force 9 bubbles -> bubble_cnt reads 7 after the 7th and stays 7.
